alt_429_tx: RTL and testbench
=============================

# alt_429_tx

ARINC 429 return-to-zero transmitter, the counterpart of the FDAU/RZ receive channel. Accepts 32-bit words over a valid/ready handshake and serialises each one onto the bipolar line pair. Bit 31 is sent first, so the receiver's shift register reproduces the word unchanged. An inter-word gap is inserted that is long enough for the receiver's idle detector to resynchronise between words.

## Interface
- HALF_BIT, default 2: clock cycles per half bit; 2 at 400 kHz gives 100 kbit/s. Legal range ≥ 1.
- GAP_BITS, default 4: NULL bit times inserted after every word. Legal range ≥ 4.
- PARITY_EN, default 1: when 1, bit 31 is replaced by odd parity over bits 30:0.
- clock  in  1  system clock (400 kHz in the FDAU build).
- reset  in  1  synchronous, active-high reset.
- data_in  in  32  word to transmit; sampled only on acceptance.
- data_valid  in  1  a word is offered on data_in.
- data_ready  out  1  transmitter idle; the word is accepted when data_valid && data_ready at a clock edge.
- line_A  out  1  HI leg: 1 during the first half of a '1' bit.
- line_B  out  1  LO leg: 1 during the first half of a '0' bit.
- busy  out  1  a word or its gap is in progress.
- tx_done  out  1  one-cycle pulse at the end of each word's gap.

## Operation
- FSM states: IDLE, HIGH, NULL, GAP. All outputs are registered.
- Reset: state=IDLE, line_A=0, line_B=0, busy=0, tx_done=0, data_ready=1, shift register cleared, counters cleared.
- IDLE
  - data_ready=1.
  - On acceptance: load the shift register with data_in, or with {~^data_in[30:0], data_in[30:0]} when PARITY_EN=1.
  - Clear bit_cnt (6-bit) and half_cnt, then go to HIGH.
- HIGH
  - line_A=sr[31], line_B=~sr[31].
  - After HALF_BIT cycles, go to NULL.
- NULL
  - line_A=line_B=0.
  - After HALF_BIT cycles, shift sr left by 1 and increment bit_cnt.
  - If bit_cnt was 31, go to GAP; otherwise go to HIGH.
- GAP
  - Lines stay 0 for 2*GAP_BITS*HALF_BIT cycles.
  - Then return to IDLE with tx_done=1 for exactly that first IDLE cycle.
- busy = (state != IDLE); data_ready = ~busy.
- line_A and line_B are never both 1, in any state or parameter setting.
- data_valid while busy is ignored. data_in is not re-sampled mid-word; the upstream source holds the word until accepted.
- half_cnt is sized for max(HALF_BIT, 2*GAP_BITS*HALF_BIT). Counters wrap only by explicit clear, never by overflow.

## Timing
- Acceptance at edge E0. Bit 31's HIGH phase is on the lines from E0 up to E0+HALF_BIT.
- Bit k (k = 31 downto 0) has its HIGH phase at E0 + 2*(31−k)*HALF_BIT and its NULL phase HALF_BIT later.
- The last NULL phase ends at E0+64*HALF_BIT, which is where GAP starts.
- IDLE is re-entered at E0+(64+2*GAP_BITS)*HALF_BIT, which is 144 at defaults. tx_done and data_ready are high after that edge.
- Back-to-back: with data_valid held high, the next acceptance falls on the following edge. The word-to-word period is (64+2*GAP_BITS)*HALF_BIT+1 clocks, i.e. 145 at defaults.
- Reset mid-word: at the next edge the lines go 0, state goes to IDLE and the word is discarded. No tx_done is produced. data_ready=1 on the cycle after reset deasserts.
- Acceptance and reset in the same cycle: reset wins and the word is not accepted.

## Test plan
- Single word, PARITY_EN=0, data_in=0xA5A5_0F0F.
  - Decode A/B over 32 bit slots MSB-first; slots must read 0xA5A5_0F0F.
  - Each HIGH phase lasts 2 clocks and each NULL phase lasts 2 clocks.
  - tx_done pulses at cycle 144.
- Parity, PARITY_EN=1:
  - data_in=0x0000_0000 must transmit 0x8000_0000.
  - data_in=0x8000_0001 must transmit 0x0000_0001.
- Back-to-back: three words with data_valid held high.
  - Acceptances must fall at cycles 0, 145 and 290.
  - Every gap must be ≥ 16 clocks of A=B=0.
  - Loopback into the receiver must write all three words to RAM addresses 0, 1, 2.
- Busy rejection: toggle data_valid with changing data_in during word 1. Only word 1 is transmitted, unchanged, and data_ready stays 0 until cycle 144.
- Reset at cycle 40 of a word: lines are 0 at cycle 41, no tx_done, and a new word accepted afterwards is transmitted intact.
- HALF_BIT=1, GAP_BITS=4: 1-clock phases, tx_done at cycle 72, and A&&B is never 1 (assertion held throughout all tests).

Source files
------------

// File: rtl/alt_429_tx.sv
// ARINC 429 return-to-zero transmitter: serialises 32-bit words MSB first onto the A/B line pair.
// Latency: bit 31 drives the lines from the acceptance edge; IDLE returns (64+2*GAP_BITS)*HALF_BIT clocks later.
// Backpressure: data_ready is low for the whole word and its gap; data_valid while busy is ignored.
module alt_429_tx #(
  parameter int HALF_BIT  = 2,
  parameter int GAP_BITS  = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        line_A,
  output logic        line_B,
  output logic        busy,
  output logic        tx_done
);

  // Gap length in clocks; half_cnt must reach whichever phase is longest.
  localparam int GAP_CYC = 2 * GAP_BITS * HALF_BIT;
  localparam int CNT_MAX = (GAP_CYC > HALF_BIT) ? GAP_CYC : HALF_BIT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, HIGH, NULL_PH, GAP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   sr, sr_nxt;
  logic [5:0]    bit_cnt, bit_cnt_nxt;
  logic [CW-1:0] half_cnt, half_cnt_nxt;
  logic          line_a_nxt, line_b_nxt, done_nxt;
  logic [31:0]   load_word;
  logic          accept;

  // With parity enabled, bit 31 becomes odd parity over the 31 payload bits.
  assign load_word = PARITY_EN ? {~^data_in[30:0], data_in[30:0]} : data_in;
  assign accept    = data_valid && data_ready;

  // Next-state and next-output logic; line outputs are computed one cycle early so they leave a register.
  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    bit_cnt_nxt  = bit_cnt;
    half_cnt_nxt = half_cnt;
    line_a_nxt   = 1'b0;
    line_b_nxt   = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = HIGH;
          sr_nxt       = load_word;
          bit_cnt_nxt  = '0;
          half_cnt_nxt = '0;
          line_a_nxt   = load_word[31];
          line_b_nxt   = ~load_word[31];
        end
      end
      HIGH: begin
        if (half_cnt == HALF_LAST) begin
          state_nxt    = NULL_PH;
          half_cnt_nxt = '0;
        end else begin
          half_cnt_nxt = half_cnt + 1'b1;
          line_a_nxt   = sr[31];
          line_b_nxt   = ~sr[31];
        end
      end
      NULL_PH: begin
        if (half_cnt == HALF_LAST) begin
          sr_nxt       = {sr[30:0], 1'b0};
          bit_cnt_nxt  = bit_cnt + 6'd1;
          half_cnt_nxt = '0;
          if (bit_cnt == 6'd31) begin
            state_nxt = GAP;
          end else begin
            // sr[30] is the bit that becomes sr[31] after this shift.
            state_nxt  = HIGH;
            line_a_nxt = sr[30];
            line_b_nxt = ~sr[30];
          end
        end else begin
          half_cnt_nxt = half_cnt + 1'b1;
        end
      end
      GAP: begin
        if (half_cnt == GAP_LAST) begin
          state_nxt    = IDLE;
          half_cnt_nxt = '0;
          done_nxt     = 1'b1;
        end else begin
          half_cnt_nxt = half_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset discards any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      half_cnt   <= '0;
      line_A     <= 1'b0;
      line_B     <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      data_ready <= 1'b1;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      bit_cnt    <= bit_cnt_nxt;
      half_cnt   <= half_cnt_nxt;
      line_A     <= line_a_nxt;
      line_B     <= line_b_nxt;
      busy       <= (state_nxt != IDLE);
      tx_done    <= done_nxt;
      data_ready <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_alt_429_tx.sv
// Bench for alt_429_tx: three instances (no parity, parity, HALF_BIT=1) checked against a timing model.
// Latency: model predicts every output cycle from the acceptance edge.
// Backpressure: stimulus holds data_valid until the model sees acceptance.
module tb_alt_429_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  rst, valid, ready, la, lb, busy, done;
  logic [31:0] din [3];

  alt_429_tx #(.HALF_BIT(2), .GAP_BITS(4), .PARITY_EN(1'b0)) u0 (
    .clock(clock), .reset(rst[0]), .data_in(din[0]), .data_valid(valid[0]), .data_ready(ready[0]),
    .line_A(la[0]), .line_B(lb[0]), .busy(busy[0]), .tx_done(done[0]));
  alt_429_tx #(.HALF_BIT(2), .GAP_BITS(4), .PARITY_EN(1'b1)) u1 (
    .clock(clock), .reset(rst[1]), .data_in(din[1]), .data_valid(valid[1]), .data_ready(ready[1]),
    .line_A(la[1]), .line_B(lb[1]), .busy(busy[1]), .tx_done(done[1]));
  alt_429_tx #(.HALF_BIT(1), .GAP_BITS(4), .PARITY_EN(1'b1)) u2 (
    .clock(clock), .reset(rst[2]), .data_in(din[2]), .data_valid(valid[2]), .data_ready(ready[2]),
    .line_A(la[2]), .line_B(lb[2]), .busy(busy[2]), .tx_done(done[2]));

  // Hand-computed expectations per instance.
  localparam int          END_LIT [3] = '{144, 144, 72};
  localparam int          NW_LIT  [3] = '{2, 6, 1};
  localparam logic [31:0] EXP0 [2] = '{32'hA5A50F0F, 32'h0123ABCD};
  localparam logic [31:0] EXP1 [6] = '{32'h80000000, 32'h00000001, 32'h12345678,
                                       32'h7FFFFFFF, 32'h80000003, 32'h8F0F0F0F};
  localparam logic [31:0] EXP2 [1] = '{32'h25A50F0F};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tmo_cnt = 0;
  bit chk_b2b = 1'b0;
  bit final_chk = 1'b0;
  bit final_done = 1'b0;

  // Model state: m_t = clocks since acceptance, -1 when idle.
  int          m_t [3] = '{-1, -1, -1};
  logic [31:0] m_w [3];
  int          acc_cnt [3] = '{0, 0, 0};
  int          acc_time [3] = '{0, 0, 0};
  int          acc_hist1 [$];
  bit          armed [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] dec_w [3];
  int          dec_n [3] = '{0, 0, 0};
  bit          prev_any [3] = '{1'b0, 1'b0, 1'b0};
  int          n_done [3] = '{0, 0, 0};

  function automatic int hb(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int end_cyc(input int i);
    return (64 + 2 * 4) * hb(i);
  endfunction

  function automatic logic [31:0] tw(input int i, input logic [31:0] d);
    if (i != 0) return {~^d[30:0], d[30:0]};
    return d;
  endfunction

  function automatic logic [31:0] exp_word(input int i, input int k);
    if (i == 0 && k < 2) return EXP0[k];
    if (i == 1 && k < 6) return EXP1[k];
    if (i == 2 && k < 1) return EXP2[k];
    return 32'hDEADBEEF;
  endfunction

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h expected=%0h", nm, inst, cyc, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Compare outputs against the model, decode the line, then predict the next edge.
  always @(negedge clock) begin
    int t, h;
    bit e_busy, e_done, e_a, e_b, any;
    for (int i = 0; i < 3; i++) begin
      t = m_t[i];
      h = hb(i);
      e_busy = (t >= 0) && (t < end_cyc(i));
      e_done = (t == end_cyc(i));
      e_a = 1'b0;
      e_b = 1'b0;
      if (t >= 0 && t < 64 * h && (t % (2 * h)) < h) begin
        e_a = m_w[i][31 - t / (2 * h)];
        e_b = ~e_a;
      end
      if (armed[i]) begin
        check("busy", i, {31'b0, busy[i]}, {31'b0, e_busy});
        check("data_ready", i, {31'b0, ready[i]}, {31'b0, ~e_busy});
        check("tx_done", i, {31'b0, done[i]}, {31'b0, e_done});
        check("line_A", i, {31'b0, la[i]}, {31'b0, e_a});
        check("line_B", i, {31'b0, lb[i]}, {31'b0, e_b});
        check("A_and_B", i, {31'b0, la[i] & lb[i]}, 32'd0);
        any = la[i] | lb[i];
        if (any && !prev_any[i]) begin
          dec_w[i] = {dec_w[i][30:0], la[i]};
          dec_n[i]++;
        end
        prev_any[i] = any;
        if (done[i] === 1'b1) begin
          check("done_cycle", i, cyc - acc_time[i], END_LIT[i]);
          check("bit_count", i, dec_n[i], 32);
          check("word", i, dec_w[i], exp_word(i, n_done[i]));
          n_done[i]++;
          dec_n[i] = 0;
          dec_w[i] = '0;
        end
      end
      if (rst[i] === 1'b1) begin
        m_t[i] = -1;
        armed[i] = 1'b1;
        dec_n[i] = 0;
        dec_w[i] = '0;
      end else if (!e_busy) begin
        if (valid[i] === 1'b1) begin
          m_t[i] = 0;
          m_w[i] = tw(i, din[i]);
          acc_cnt[i]++;
          acc_time[i] = cyc + 1;
          if (i == 1) acc_hist1.push_back(cyc + 1);
          dec_n[i] = 0;
          dec_w[i] = '0;
        end else begin
          m_t[i] = -1;
        end
      end else begin
        m_t[i] = t + 1;
      end
    end
    if (cyc == 2) begin
      check("tw_parity_zero", 1, tw(1, 32'h00000000), 32'h80000000);
      check("tw_parity_msb", 1, tw(1, 32'h80000001), 32'h00000001);
      check("tw_no_parity", 0, tw(0, 32'hA5A50F0F), 32'hA5A50F0F);
    end
    if (chk_b2b && acc_hist1.size() >= 3) begin
      check("b2b_period_1", 1, acc_hist1[acc_hist1.size()-2] - acc_hist1[acc_hist1.size()-3], 145);
      check("b2b_period_2", 1, acc_hist1[acc_hist1.size()-1] - acc_hist1[acc_hist1.size()-2], 145);
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      for (int i = 0; i < 3; i++) check("words_done", i, n_done[i], NW_LIT[i]);
      check("timeouts", 0, tmo_cnt, 0);
    end
  end

  task automatic send(input int i, input logic [31:0] d);
    int c0;
    c0 = acc_cnt[i];
    din[i] = d;
    valid[i] = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clock); #1;
      if (acc_cnt[i] != c0) break;
    end
    if (acc_cnt[i] == c0) tmo_cnt++;
    valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 400; k++) begin
      @(posedge clock); #1;
      if (m_t[i] < 0) break;
    end
    if (m_t[i] >= 0) tmo_cnt++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b [3];
    int c0;
    b2b[0] = 32'h12345678;
    b2b[1] = 32'hFFFFFFFF;
    b2b[2] = 32'h00000003;
    rst = '1;
    valid = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (3) @(posedge clock);
    #1 rst = '0;
    repeat (2) @(posedge clock);
    #1;

    // Single word, no parity.
    send(0, 32'hA5A50F0F);
    wait_idle(0);

    // Parity cases.
    send(1, 32'h00000000);
    wait_idle(1);
    send(1, 32'h80000001);
    wait_idle(1);

    // Back-to-back with data_valid held high.
    valid[1] = 1'b1;
    for (int w = 0; w < 3; w++) begin
      din[1] = b2b[w];
      c0 = acc_cnt[1];
      for (int k = 0; k < 400; k++) begin
        @(posedge clock); #1;
        if (acc_cnt[1] != c0) break;
      end
      if (acc_cnt[1] == c0) tmo_cnt++;
    end
    valid[1] = 1'b0;
    wait_idle(1);
    chk_b2b = 1'b1;
    @(posedge clock); #1;
    chk_b2b = 1'b0;

    // Busy rejection: offers during the word must be ignored.
    send(0, 32'h0123ABCD);
    for (int k = 0; k < 100; k++) begin
      valid[0] = k[0];
      din[0] = $urandom;
      @(posedge clock); #1;
    end
    valid[0] = 1'b0;
    wait_idle(0);

    // Reset at cycle 40 of a word, then a fresh word.
    send(1, 32'h55AA55AA);
    repeat (39) @(posedge clock);
    #1 rst[1] = 1'b1;
    @(posedge clock);
    #1 rst[1] = 1'b0;
    send(1, 32'h0F0F0F0F);
    wait_idle(1);

    // One-clock phases.
    send(2, 32'hA5A50F0F);
    wait_idle(2);

    final_chk = 1'b1;
    @(negedge clock);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
